// File: rtl/mux_disp_scan_ctrl.sv
// Time-multiplexed octal display scanner: blanks, shows each digit in turn and
// swaps in newly loaded data only at frame boundaries so a frame never tears.
module mux_disp_scan_ctrl #(
    parameter int NUM_DIGITS   = 5,
    parameter int TICK_DIV     = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic [3*NUM_DIGITS-1:0] data_i,
    input  logic                    load_i,
    output logic [2:0]              code_o,
    output logic [2:0]              sel_o,
    output logic [NUM_DIGITS-1:0]   digit_en_o,
    output logic                    blank_o,
    output logic                    frame_done_o
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [PW-1:0] PS_LAST  = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BL_LAST  = BW'(BLANK_CYCLES - 1);
    localparam logic [2:0]    SEL_LAST = 3'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

    state_t                  r_state, w_state_nx;
    logic [2:0]              r_sel, w_sel_nx;
    logic [PW-1:0]           r_ps, w_ps_nx;
    logic [BW-1:0]           r_bcnt, w_bcnt_nx;
    logic [3*NUM_DIGITS-1:0] r_shown, w_shown_nx;
    logic [3*NUM_DIGITS-1:0] r_pending, w_pending_nx;
    logic                    w_fdone_nx;
    logic [2:0]              w_code_nx;
    logic [NUM_DIGITS-1:0]   w_den_nx;

    always_comb begin
        w_state_nx   = r_state;
        w_sel_nx     = r_sel;
        w_ps_nx      = r_ps;
        w_bcnt_nx    = r_bcnt;
        w_shown_nx   = r_shown;
        w_pending_nx = load_i ? data_i : r_pending;
        w_fdone_nx   = 1'b0;

        if (!en_i) begin
            w_state_nx = S_IDLE;
            w_sel_nx   = 3'd0;
            w_ps_nx    = '0;
            w_bcnt_nx  = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_shown_nx   = data_i;
                    w_pending_nx = data_i;
                    w_state_nx   = S_BLANK;
                    w_sel_nx     = 3'd0;
                    w_bcnt_nx    = '0;
                end
                S_BLANK: begin
                    if (r_bcnt == BL_LAST) begin
                        w_state_nx = S_SHOW;
                        w_ps_nx    = '0;
                        w_bcnt_nx  = '0;
                    end else begin
                        w_bcnt_nx = r_bcnt + 1'b1;
                    end
                end
                S_SHOW: begin
                    if (r_ps == PS_LAST) begin
                        w_state_nx = S_BLANK;
                        w_ps_nx    = '0;
                        w_bcnt_nx  = '0;
                        if (r_sel == SEL_LAST) begin
                            // Frame boundary: a load arriving this very cycle bypasses pending
                            w_sel_nx   = 3'd0;
                            w_fdone_nx = 1'b1;
                            w_shown_nx = load_i ? data_i : r_pending;
                        end else begin
                            w_sel_nx = r_sel + 3'd1;
                        end
                    end else begin
                        w_ps_nx = r_ps + 1'b1;
                    end
                end
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_code_nx = 3'd0;
        w_den_nx  = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (w_sel_nx == 3'(k)) begin
                w_code_nx = w_shown_nx[3*k +: 3];
            end
            w_den_nx[k] = (w_state_nx == S_SHOW) && (w_sel_nx == 3'(k));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_sel        <= 3'd0;
            r_ps         <= '0;
            r_bcnt       <= '0;
            r_shown      <= '0;
            r_pending    <= '0;
            code_o       <= 3'd0;
            sel_o        <= 3'd0;
            digit_en_o   <= '0;
            blank_o      <= 1'b1;
            frame_done_o <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_sel        <= w_sel_nx;
            r_ps         <= w_ps_nx;
            r_bcnt       <= w_bcnt_nx;
            r_shown      <= w_shown_nx;
            r_pending    <= w_pending_nx;
            code_o       <= w_code_nx;
            sel_o        <= w_sel_nx;
            digit_en_o   <= w_den_nx;
            blank_o      <= (w_state_nx != S_SHOW);
            frame_done_o <= w_fdone_nx;
        end
    end

endmodule

// File: tb/tb_mux_disp_scan_ctrl.sv
// Directed bench for mux_disp_scan_ctrl with 5 digits, 4-cycle show, 2-cycle blank.
module tb_mux_disp_scan_ctrl;

    localparam int ND = 5;
    localparam int TD = 4;
    localparam int BC = 2;
    localparam int DP = BC + TD;
    localparam int FR = ND * DP;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          en_i;
    logic [14:0]   data_i;
    logic          load_i;
    logic [2:0]    code_o;
    logic [2:0]    sel_o;
    logic [ND-1:0] digit_en_o;
    logic          blank_o;
    logic          frame_done_o;
    logic [12:0]   obs;

    int checks   = 0;
    int failures = 0;

    mux_disp_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .TICK_DIV    (TD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .data_i      (data_i),
        .load_i      (load_i),
        .code_o      (code_o),
        .sel_o       (sel_o),
        .digit_en_o  (digit_en_o),
        .blank_o     (blank_o),
        .frame_done_o(frame_done_o)
    );

    always #5 clk = ~clk;

    assign obs = {sel_o, digit_en_o, blank_o, frame_done_o, code_o};

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Expected {sel, digit_en, blank, frame_done, code} at position p of a frame showing word w
    function automatic logic [12:0] exp_vec(int p, logic [14:0] w, bit fd);
        int d;
        int s;
        logic [4:0] den;
        d   = p / DP;
        s   = p % DP;
        den = (s >= BC) ? 5'(1 << d) : 5'd0;
        return {3'(d), den, (s < BC), (fd && (p == 0)), w[3*d +: 3]};
    endfunction

    task automatic test_reset;
        rst_i  = 1'b1;
        en_i   = 1'b0;
        load_i = 1'b0;
        data_i = 15'o00000;
        #3;
        checks++;
        if (obs !== 13'b000_00000_1_0_000) begin
            failures++;
            $display("FAIL reset_async got=%b exp=%b", obs, 13'b000_00000_1_0_000);
        end
        step;
        step;
        checks++;
        if (obs !== 13'b000_00000_1_0_000) begin
            failures++;
            $display("FAIL reset_held got=%b exp=%b", obs, 13'b000_00000_1_0_000);
        end
        rst_i = 1'b0;
        step;
        checks++;
        if (obs !== 13'b000_00000_1_0_000) begin
            failures++;
            $display("FAIL idle_dark got=%b exp=%b", obs, 13'b000_00000_1_0_000);
        end
    endtask

    task automatic test_scan;
        data_i = 15'o01234;
        en_i   = 1'b1;
        step;
        for (int f = 0; f < 2; f++) begin
            for (int p = 0; p < FR; p++) begin
                checks++;
                if (obs !== exp_vec(p, 15'o01234, f > 0)) begin
                    failures++;
                    $display("FAIL scan f=%0d p=%0d got=%b exp=%b", f, p, obs, exp_vec(p, 15'o01234, f > 0));
                end
                step;
            end
        end
    endtask

    task automatic test_midframe_load;
        for (int p = 0; p < FR; p++) begin
            checks++;
            if (obs !== exp_vec(p, 15'o01234, 1'b1)) begin
                failures++;
                $display("FAIL midload_old p=%0d got=%b exp=%b", p, obs, exp_vec(p, 15'o01234, 1'b1));
            end
            if (p == 2*DP + BC) begin
                load_i = 1'b1;
                data_i = 15'o56777;
            end else if (p == 2*DP + BC + 1) begin
                load_i = 1'b0;
                data_i = 15'o00000;
            end
            step;
        end
        for (int p = 0; p < FR - 1; p++) begin
            checks++;
            if (obs !== exp_vec(p, 15'o56777, 1'b1)) begin
                failures++;
                $display("FAIL midload_new p=%0d got=%b exp=%b", p, obs, exp_vec(p, 15'o56777, 1'b1));
            end
            step;
        end
    endtask

    task automatic test_boundary_load;
        checks++;
        if (obs !== exp_vec(FR - 1, 15'o56777, 1'b1)) begin
            failures++;
            $display("FAIL bnd_last got=%b exp=%b", obs, exp_vec(FR - 1, 15'o56777, 1'b1));
        end
        load_i = 1'b1;
        data_i = 15'o77777;
        step;
        load_i = 1'b0;
        data_i = 15'o12345;
        for (int p = 0; p < FR; p++) begin
            checks++;
            if (obs !== exp_vec(p, 15'o77777, 1'b1)) begin
                failures++;
                $display("FAIL bnd_bypass p=%0d got=%b exp=%b", p, obs, exp_vec(p, 15'o77777, 1'b1));
            end
            step;
        end
    endtask

    task automatic test_enable_drop;
        for (int p = 0; p <= 3*DP + BC; p++) begin
            checks++;
            if (obs !== exp_vec(p, 15'o77777, 1'b1)) begin
                failures++;
                $display("FAIL endrop_pre p=%0d got=%b exp=%b", p, obs, exp_vec(p, 15'o77777, 1'b1));
            end
            if (p == 3*DP + BC) en_i = 1'b0;
            step;
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs !== 13'b000_00000_1_0_111) begin
                failures++;
                $display("FAIL endrop_idle i=%0d got=%b exp=%b", i, obs, 13'b000_00000_1_0_111);
            end
            step;
        end
        data_i = 15'o01234;
        en_i   = 1'b1;
        step;
        for (int p = 0; p < FR; p++) begin
            checks++;
            if (obs !== exp_vec(p, 15'o01234, 1'b0)) begin
                failures++;
                $display("FAIL reenable p=%0d got=%b exp=%b", p, obs, exp_vec(p, 15'o01234, 1'b0));
            end
            step;
        end
        checks++;
        if (obs !== exp_vec(0, 15'o01234, 1'b1)) begin
            failures++;
            $display("FAIL reenable_wrap got=%b exp=%b", obs, exp_vec(0, 15'o01234, 1'b1));
        end
    endtask

    task automatic test_async_reset;
        data_i = 15'o65432;
        step;
        step;
        step;
        checks++;
        if (obs !== exp_vec(3, 15'o01234, 1'b1)) begin
            failures++;
            $display("FAIL arst_pre got=%b exp=%b", obs, exp_vec(3, 15'o01234, 1'b1));
        end
        #2;
        rst_i = 1'b1;
        #1;
        checks++;
        if (obs !== 13'b000_00000_1_0_000) begin
            failures++;
            $display("FAIL arst_immediate got=%b exp=%b", obs, 13'b000_00000_1_0_000);
        end
        step;
        rst_i = 1'b0;
        step;
        for (int p = 0; p < FR; p++) begin
            checks++;
            if (obs !== exp_vec(p, 15'o65432, 1'b0)) begin
                failures++;
                $display("FAIL arst_restart p=%0d got=%b exp=%b", p, obs, exp_vec(p, 15'o65432, 1'b0));
            end
            step;
        end
        checks++;
        if (obs !== exp_vec(0, 15'o65432, 1'b1)) begin
            failures++;
            $display("FAIL arst_wrap got=%b exp=%b", obs, exp_vec(0, 15'o65432, 1'b1));
        end
    endtask

    initial begin
        test_reset;
        test_scan;
        test_midframe_load;
        test_boundary_load;
        test_enable_drop;
        test_async_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_disp_scan_ctrl.md
Name: mux_disp_scan_ctrl

Overview:
Time-multiplexed scan controller for the octal display path. It takes a packed word of NUM_DIGITS 3-bit octal codes and sequences them one digit at a time onto the shared oct7seg decoder input. It drives the one-hot digit enables for the display. Blanking gaps between digits suppress ghosting, and frame-boundary loading keeps the displayed word tear-free. It sits between the switch/data source and the single oct7seg instance on the board.

Parameters:
NUM_DIGITS, 5, number of octal digits scanned; legal range 2..8.
TICK_DIV, 50000, clock cycles each digit is shown; must be >= 2.
BLANK_CYCLES, 2, clock cycles of all-off gap before each digit; must be >= 1.

Ports:
clk_i  input  1  system clock.
rst_i  input  1  reset; asynchronous, active-high.
en_i  input  1  scan enable; 0 forces idle with display dark.
data_i  input  3*NUM_DIGITS  packed octal codes; digit k is data_i[3k+2:3k].
load_i  input  1  single-cycle request to capture data_i for display.
code_o  output  3  octal code to shared oct7seg c_i.
sel_o  output  3  index of current digit, 0..NUM_DIGITS-1.
digit_en_o  output  NUM_DIGITS  one-hot active-high digit enable; all 0 when dark.
blank_o  output  1  1 whenever digit_en_o is all 0.
frame_done_o  output  1  one-cycle pulse when the last digit's show period ends.

Behaviour:
- Reset (async, any time): state IDLE, sel_o=0, digit_en_o=0, blank_o=1, frame_done_o=0, code_o=0, shown and pending registers=0, prescaler=0, blank counter=0.
- All outputs are registered. code_o always equals shown[3*sel_o +: 3].
- State IDLE:
  - Outputs are dark and sel_o=0.
  - When en_i=1, copy data_i directly into shown and pending, then go to BLANK with sel_o=0.
- State BLANK:
  - digit_en_o=0, blank_o=1.
  - Stays exactly BLANK_CYCLES cycles, then goes to SHOW. Prescaler is cleared on entry to SHOW.
- State SHOW:
  - digit_en_o has bit sel_o set, blank_o=0.
  - Prescaler counts 0..TICK_DIV-1, so SHOW lasts exactly TICK_DIV cycles.
  - On the terminal count with sel_o < NUM_DIGITS-1: sel_o increments and state goes to BLANK.
  - On the terminal count with sel_o = NUM_DIGITS-1: sel_o wraps to 0, frame_done_o pulses for 1 cycle, shown <= pending, and state goes to BLANK.
- Frame length = NUM_DIGITS*(BLANK_CYCLES+TICK_DIV) cycles.
- load_i: captures data_i into pending on any cycle. shown changes only at a frame boundary, never mid-frame.
- load_i in the same cycle as a frame boundary: shown takes data_i directly (bypass), and pending also takes data_i.
- en_i falls in any state: next cycle is IDLE and outputs are dark. No frame_done_o pulse. Pending contents are retained but overwritten on re-enable.
- digit_en_o is never multi-hot. Between any two enabled digits there are at least BLANK_CYCLES dark cycles, including across the wrap from digit NUM_DIGITS-1 to digit 0.
- sel_o never reaches NUM_DIGITS.

Test Plan:
(All scenarios use NUM_DIGITS=5, TICK_DIV=4, BLANK_CYCLES=2, frame = 30 cycles.)
1. Reset, then en_i=1 with data_i=15'o01234 -> 2 blank cycles, then sel_o=0 with code_o=4 and digit_en_o=00001 for 4 cycles. Subsequent digits show code_o=3,2,1,0 with digit_en_o=00010,00100,01000,10000.
2. Run two frames -> frame_done_o pulses exactly once per 30 cycles, in the cycle after digit 4's last show cycle. Each wrap to sel_o=0 is preceded by 2 dark cycles.
3. Mid-frame (sel_o=2), pulse load_i with data_i=15'o56777 -> digits 2..4 still show 2,1,0. The next frame shows 7,7,7,6,5.
4. load_i=1 with data_i=15'o77777 in the same cycle as the frame boundary -> next frame shows 7 on all digits.
5. Drop en_i during SHOW of digit 3 -> next cycle digit_en_o=0, blank_o=1, sel_o=0. Re-enable -> restarts at digit 0 after 2 blank cycles using current data_i.
6. Assert rst_i asynchronously mid-SHOW -> outputs go to reset values immediately, with no clock edge required. After release and with en_i=1, scanning restarts cleanly from digit 0.
